// File: rtl/round_manager.sv
// Match flow controller: pre-round countdown, round timer, per-round scoring,
// best-of-N result and inter-round hold; re-arms and gates the game core.
module round_manager #(
    parameter int TICKS_PER_SEC  = 100_000_000,
    parameter int COUNTDOWN_SEC  = 3,
    parameter int ROUND_TIME_SEC = 99,
    parameter int END_HOLD_SEC   = 3,
    parameter int ROUNDS_TO_WIN  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic [1:0] finish,
    input  logic [3:0] p1_health,
    input  logic [3:0] p2_health,
    output logic       game_reset,
    output logic       input_enable,
    output logic [2:0] state,
    output logic [1:0] countdown,
    output logic [6:0] round_time,
    output logic [2:0] round_num,
    output logic [1:0] p1_rounds,
    output logic [1:0] p2_rounds,
    output logic [1:0] round_winner,
    output logic [1:0] match_winner
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] COUNTDOWN = 3'd1;
    localparam logic [2:0] FIGHT     = 3'd2;
    localparam logic [2:0] ROUND_END = 3'd3;
    localparam logic [2:0] MATCH_END = 3'd4;

    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int HW = (END_HOLD_SEC > 1) ? $clog2(END_HOLD_SEC) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(END_HOLD_SEC - 1);
    localparam logic [1:0]    CD_INIT   = 2'(COUNTDOWN_SEC);
    localparam logic [6:0]    RT_INIT   = 7'(ROUND_TIME_SEC);
    localparam logic [1:0]    WIN       = 2'(ROUNDS_TO_WIN);

    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] P1   = 2'b01;
    localparam logic [1:0] P2   = 2'b11;

    logic [TW-1:0] tick_cnt;
    logic [HW-1:0] hold_cnt;
    logic          start_q;
    logic [2:0]    state_n;
    logic          tick;
    logic          start_rise;
    logic          time_up;
    logic          hold_done;
    logic          match_done;
    logic [1:0]    time_winner;
    logic [1:0]    end_winner;

    assign tick       = tick_cnt == TICK_LAST;
    assign start_rise = start_btn & ~start_q;
    assign time_up    = tick && round_time == 7'd1;
    assign hold_done  = tick && hold_cnt == HOLD_LAST;
    assign match_done = p1_rounds == WIN || p2_rounds == WIN;

    assign time_winner = (p1_health > p2_health) ? P1 :
                         (p2_health > p1_health) ? P2 : NONE;

    // A KO beats a timeout landing on the same cycle.
    assign end_winner = finish[0] ? (finish[1] ? P2 : P1) : time_winner;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start_rise) state_n = COUNTDOWN;
            end
            COUNTDOWN: begin
                if (tick && countdown == 2'd1) state_n = FIGHT;
            end
            FIGHT: begin
                if (finish[0] || time_up) state_n = ROUND_END;
            end
            ROUND_END: begin
                if (hold_done) state_n = match_done ? MATCH_END : COUNTDOWN;
            end
            MATCH_END: begin
                if (start_rise) state_n = COUNTDOWN;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            game_reset   <= 1'b0;
            input_enable <= 1'b0;
            countdown    <= 2'd0;
            round_time   <= RT_INIT;
            round_num    <= 3'd0;
            p1_rounds    <= 2'd0;
            p2_rounds    <= 2'd0;
            round_winner <= NONE;
            match_winner <= NONE;
            tick_cnt     <= '0;
            hold_cnt     <= '0;
            start_q      <= 1'b0;
        end else begin
            start_q  <= start_btn;
            state    <= state_n;
            // Restarting on every transition keeps each state's first second full length.
            tick_cnt <= (state_n != state || tick) ? '0 : tick_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        round_num <= 3'd1;
                        countdown <= CD_INIT;
                    end
                end
                COUNTDOWN: begin
                    if (tick) begin
                        countdown <= countdown - 2'd1;
                        if (countdown == 2'd1) begin
                            round_time   <= RT_INIT;
                            game_reset   <= 1'b1;
                            input_enable <= 1'b1;
                        end
                    end
                end
                FIGHT: begin
                    if (finish[0] || time_up) begin
                        round_winner <= end_winner;
                        input_enable <= 1'b0;
                        hold_cnt     <= '0;
                        if (!finish[0]) round_time <= 7'd0;
                        if (end_winner == P1) p1_rounds <= p1_rounds + 2'd1;
                        if (end_winner == P2) p2_rounds <= p2_rounds + 2'd1;
                    end else if (tick) begin
                        round_time <= round_time - 7'd1;
                    end
                end
                ROUND_END: begin
                    if (hold_done) begin
                        if (p1_rounds == WIN) begin
                            match_winner <= P1;
                        end else if (p2_rounds == WIN) begin
                            match_winner <= P2;
                        end else begin
                            round_num  <= (round_num == 3'd7) ? 3'd7 : round_num + 3'd1;
                            countdown  <= CD_INIT;
                            game_reset <= 1'b0;
                        end
                    end else if (tick) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                MATCH_END: begin
                    if (start_rise) begin
                        p1_rounds    <= 2'd0;
                        p2_rounds    <= 2'd0;
                        round_winner <= NONE;
                        match_winner <= NONE;
                        round_num    <= 3'd1;
                        countdown    <= CD_INIT;
                        game_reset   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
